// File: rtl/quadram_arbiter.sv
// Two-port arbiter sharing one quadram (32-bit, byte enables, 1-cycle read) between a
// host port (0) and an engine port (1): round-robin grants, burst locks with a timeout.
module quadram_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int LOCK_MAX   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [3:0]            we0,
    input  logic [3:0]            we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [31:0]           wdata0,
    input  logic [31:0]           wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [31:0]           rdata,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout,
    output logic                  lock_timeout
);

    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             prio_reg, prio_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout_reg, timeout_next;

    logic [1:0]            req_vec;
    logic [1:0]            lock_vec;
    logic [1:0]            gnt_vec;
    logic [1:0]            rvalid_vec;
    logic [3:0]            we_vec    [2];
    logic [ADDR_WIDTH-1:0] addr_vec  [2];
    logic [31:0]           wdata_vec [2];

    logic             own_idx;
    logic [CNT_W-1:0] cnt_inc;
    logic             lim_hit;
    logic             sel;

    assign req_vec      = {req1, req0};
    assign lock_vec     = {lock1, lock0};
    assign we_vec[0]    = we0;
    assign we_vec[1]    = we1;
    assign addr_vec[0]  = addr0;
    assign addr_vec[1]  = addr1;
    assign wdata_vec[0] = wdata0;
    assign wdata_vec[1] = wdata1;

    assign gnt0         = gnt_vec[0];
    assign gnt1         = gnt_vec[1];
    assign rvalid0      = rvalid_vec[0];
    assign rvalid1      = rvalid_vec[1];
    assign rdata        = ram_dout;
    assign lock_timeout = timeout_reg;

    assign own_idx = (state_reg == ST_OWN1);
    assign cnt_inc = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
    assign lim_hit = (LOCK_MAX != 0) && (cnt_inc == CNT_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            prio_reg    <= 1'b0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            prio_reg    <= prio_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    // prio_reg holds the index of the port that wins a contested IDLE cycle.
    always_comb begin
        state_next   = state_reg;
        prio_next    = prio_reg;
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;
        gnt_vec      = 2'b00;
        case (state_reg)
            ST_IDLE: begin
                if (req_vec == 2'b11) begin
                    gnt_vec[prio_reg] = 1'b1;
                end else begin
                    gnt_vec = req_vec;
                end
                if (gnt_vec[0] && lock_vec[0]) begin
                    state_next = ST_OWN0;
                    cnt_next   = '0;
                end else if (gnt_vec[1] && lock_vec[1]) begin
                    state_next = ST_OWN1;
                    cnt_next   = '0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                gnt_vec[own_idx] = req_vec[own_idx];
                cnt_next         = cnt_inc;
                // A voluntary release in the limit cycle wins over the timeout.
                if (!lock_vec[own_idx]) begin
                    state_next = ST_IDLE;
                end else if (lim_hit) begin
                    state_next   = ST_IDLE;
                    timeout_next = 1'b1;
                    prio_next    = ~own_idx;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (gnt_vec != 2'b00) begin
            prio_next = gnt_vec[0];
        end
        if (reset) begin
            gnt_vec = 2'b00;
        end
    end

    assign sel = gnt_vec[1];

    always_comb begin
        ram_en   = |gnt_vec;
        ram_we   = 4'b0000;
        ram_addr = '0;
        ram_din  = '0;
        if (ram_en) begin
            ram_we   = we_vec[sel];
            ram_addr = addr_vec[sel];
            ram_din  = wdata_vec[sel];
        end
    end

    // Masking with reset drops a read return already in flight when reset arrives.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
        logic rvalid_reg;
        always_ff @(posedge clk) begin
            if (reset) begin
                rvalid_reg <= 1'b0;
            end else begin
                rvalid_reg <= gnt_vec[gi] && (we_vec[gi] == 4'b0000);
            end
        end
        assign rvalid_vec[gi] = rvalid_reg & ~reset;
    end

endmodule

// File: tb/tb_quadram_arbiter.sv
// Randomized bench for quadram_arbiter: a behavioural arbitration model predicts grants
// and RAM drive each cycle; read returns are queued and checked by a separate monitor.
module tb_quadram_arbiter;

    localparam int AW   = 11;
    localparam int LMAX = 12;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [3:0]    we0 = 4'b0, we1 = 4'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [31:0]   wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, ram_en, lock_timeout;
    logic [31:0]   rdata, ram_din;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_dout = '0;

    quadram_arbiter #(.ADDR_WIDTH(AW), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .lock_timeout(lock_timeout)
    );

    // The quadram itself, driven only by the DUT.
    logic [31:0] ram_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) begin
                ram_dout <= ram_mem[ram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Stimulus the next cycle will apply
    logic          s_reset;
    logic          s_req  [2];
    logic          s_lock [2];
    logic [3:0]    s_we   [2];
    logic [AW-1:0] s_addr [2];
    logic [31:0]   s_data [2];

    // Reference model
    logic [31:0] ref_mem [0:DEPTH-1];
    int          m_owner;
    int          m_fav;
    int          m_cycles;
    logic        m_timeout;
    logic [1:0]  g_last;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    task automatic set_port(input int p, input logic r, input logic l, input logic [3:0] w,
                            input logic [AW-1:0] a, input logic [31:0] d);
        s_req[p]  = r;
        s_lock[p] = l;
        s_we[p]   = w;
        s_addr[p] = a;
        s_data[p] = d;
    endtask

    task automatic idle_all();
        set_port(0, 1'b0, 1'b0, 4'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, 4'b0, '0, '0);
    endtask

    task automatic model_eval();
        int            win;
        logic [1:0]    e_gnt;
        logic [3:0]    e_we;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_din;
        chk("lock_timeout", lock_timeout, m_timeout);
        win = -1;
        if (!s_reset) begin
            if (m_owner >= 0) begin
                if (s_req[m_owner]) win = m_owner;
            end else if (s_req[0] && s_req[1]) begin
                win = m_fav;
            end else if (s_req[0]) begin
                win = 0;
            end else if (s_req[1]) begin
                win = 1;
            end
        end
        e_gnt = 2'b00; e_we = 4'b0; e_addr = '0; e_din = '0;
        if (win >= 0) begin
            e_gnt[win] = 1'b1;
            e_we   = s_we[win];
            e_addr = s_addr[win];
            e_din  = s_data[win];
        end
        chk("gnt", {gnt1, gnt0}, e_gnt);
        chk("ram_en", ram_en, (win >= 0));
        chk("ram_we", ram_we, e_we);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_din", ram_din, e_din);
        g_last = e_gnt;
        if (s_reset) begin
            m_owner = -1; m_fav = 0; m_cycles = 0; m_timeout = 1'b0;
            sb.delete();
            return;
        end
        if (win >= 0) begin
            m_fav = 1 - win;
            if (e_we == 4'b0000) begin
                sb.push_back('{win, ref_mem[e_addr], cyc + 1});
            end else begin
                $display("write port%0d addr=%0d we=%b data=%h", win, e_addr, e_we, e_din);
                for (int b = 0; b < 4; b++) begin
                    if (e_we[b]) ref_mem[e_addr][8*b +: 8] = e_din[8*b +: 8];
                end
            end
        end
        if (m_owner >= 0) begin
            m_cycles++;
            if (!s_lock[m_owner]) begin
                m_owner = -1;
            end else if (LMAX > 0 && m_cycles >= LMAX) begin
                m_timeout = 1'b1;
                m_fav     = 1 - m_owner;
                m_owner   = -1;
            end
        end else if (win >= 0 && s_lock[win]) begin
            m_owner  = win;
            m_cycles = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        reset  = s_reset;
        req0   = s_req[0];  req1   = s_req[1];
        lock0  = s_lock[0]; lock1  = s_lock[1];
        we0    = s_we[0];   we1    = s_we[1];
        addr0  = s_addr[0]; addr1  = s_addr[1];
        wdata0 = s_data[0]; wdata1 = s_data[1];
        @(negedge clk);
        model_eval();
    endtask

    task automatic rand_port(input int p);
        if (!s_req[p] || g_last[p]) begin
            s_req[p]  = ($urandom_range(0, 99) < 60);
            s_we[p]   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            s_addr[p] = AW'($urandom_range(0, 31));
            s_data[p] = $urandom;
        end
        if ($urandom_range(0, 9) == 0) s_lock[p] = ~s_lock[p];
    endtask

    // Read-return monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rvalid0 || rvalid1) begin
                if (sb.size() == 0) begin
                    chk("rvalid_unexpected", {rvalid1, rvalid0}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    chk("rvalid_port", {rvalid1, rvalid0}, (e.port == 0) ? 2'b01 : 2'b10);
                    chk("rdata", rdata, e.data);
                    chk("rvalid_latency", cyc, e.due);
                    $display("read  port%0d data=%h", e.port, rdata);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("rvalid_missing", {rvalid1, rvalid0}, (e.port == 0) ? 2'b01 : 2'b10);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] v;
            v = $urandom;
            ram_mem[i] = v;
            ref_mem[i] = v;
        end
        ram_mem[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        m_owner = -1; m_fav = 0; m_cycles = 0; m_timeout = 1'b0; g_last = 2'b00;
        idle_all();
        s_reset = 1'b1;
        repeat (3) step();
        s_reset = 1'b0;

        // Single read of the preloaded word
        set_port(0, 1'b1, 1'b0, 4'b0, 5, '0); step();
        idle_all(); step();

        // Contested reads straight after reset alternate starting with port 0
        s_reset = 1'b1; step(); s_reset = 1'b0;
        set_port(0, 1'b1, 1'b0, 4'b0, 1, '0);
        set_port(1, 1'b1, 1'b0, 4'b0, 2, '0);
        repeat (4) step();
        idle_all(); step();

        // Write from port 1, read back from port 0
        set_port(1, 1'b1, 1'b0, 4'hF, 7, 32'h12345678); step();
        idle_all(); step();
        set_port(0, 1'b1, 1'b0, 4'b0, 7, '0); step();
        idle_all(); step();

        // Port 1 burst lock starves port 0 until released
        set_port(1, 1'b1, 1'b1, 4'b0, 4, '0); step();
        for (int i = 0; i < 10; i++) begin
            set_port(0, 1'b1, 1'b0, 4'b0, 3, '0);
            s_req[1] = i[0];
            step();
        end
        s_lock[1] = 1'b0; step();
        s_req[1] = 1'b0; step();
        idle_all(); step();

        // Port 0 holds lock forever: forced release and handover to port 1
        set_port(0, 1'b1, 1'b1, 4'b0, 9, '0);
        set_port(1, 1'b1, 1'b0, 4'b0, 10, '0);
        repeat (2 * LMAX + 4) step();
        idle_all(); step();

        // Reset right after a granted read
        set_port(0, 1'b1, 1'b0, 4'b0, 5, '0); step();
        idle_all(); s_reset = 1'b1;
        repeat (2) step();
        s_reset = 1'b0; step();

        // Random traffic with occasional resets
        repeat (3000) begin
            rand_port(0);
            rand_port(1);
            s_reset = ($urandom_range(0, 299) == 0);
            step();
        end

        s_reset = 1'b0;
        idle_all();
        repeat (3) step();
        chk("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
